// File: rtl/move_scheduler.sv
// Buffered stepper-move sequencer: a ring FIFO of move segments feeding a DDA tick engine
// that emits step/dir pulses and reports buffer status back to the host.
module move_scheduler #(
  parameter int unsigned BUFFER_BITS = 2,
  parameter int unsigned DUR_W       = 64,
  parameter int unsigned INC_W       = 64,
  parameter int unsigned DIV_W       = 24
) (
  input  logic                   CLK,
  input  logic                   resetn,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic                   push_dir,
  input  logic [DUR_W-1:0]       push_duration,
  input  logic [INC_W-1:0]       push_increment,
  input  logic [INC_W-1:0]       push_incinc,
  input  logic [DIV_W-1:0]       clock_divisor,
  input  logic                   enable,
  input  logic                   abort,
  output logic                   step,
  output logic                   dir,
  output logic                   busy,
  output logic                   move_done,
  output logic [BUFFER_BITS:0]   fill_level,
  output logic                   underrun
);

  localparam int unsigned Depth = 1 << BUFFER_BITS;
  localparam int unsigned CntW  = BUFFER_BITS + 1;
  // Subtracted from the accumulator each time a step is emitted.
  localparam logic [INC_W-1:0] StepSub = {1'b0, {(INC_W-1){1'b1}}} - INC_W'(100);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  // Segment storage; the executing segment stays at the head until retired.
  logic                   dir_mem    [Depth];
  logic [DUR_W-1:0]       dur_mem    [Depth];
  logic [INC_W-1:0]       inc_mem    [Depth];
  logic [INC_W-1:0]       incinc_mem [Depth];

  logic [BUFFER_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUFFER_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;

  state_e                 state_q, state_d;
  logic [DUR_W-1:0]       tick_q, tick_d;
  logic [INC_W-1:0]       inc_q, inc_d;
  logic [INC_W-1:0]       incinc_q, incinc_d;
  logic [INC_W-1:0]       acc_q, acc_d;
  logic [DIV_W-1:0]       clkcnt_q, clkcnt_d;
  logic                   dir_q, dir_d;
  logic                   underrun_q, underrun_d;

  logic                   clear;
  logic                   head_dir;
  logic [DUR_W-1:0]       head_dur;
  logic [INC_W-1:0]       head_inc;
  logic [INC_W-1:0]       head_incinc;
  logic [DIV_W-1:0]       div_eff;
  logic [DIV_W-1:0]       cnt_next;
  logic [INC_W-1:0]       acc_sum;
  logic                   tick_fire;
  logic                   step_hit;
  logic                   load_zero;
  logic                   run_done;
  logic                   retire;
  logic                   push_fire;
  logic                   others_stored;

  assign clear       = !resetn || abort;
  assign head_dir    = dir_mem[rd_ptr_q];
  assign head_dur    = dur_mem[rd_ptr_q];
  assign head_inc    = inc_mem[rd_ptr_q];
  assign head_incinc = incinc_mem[rd_ptr_q];

  assign div_eff   = (clock_divisor == '0) ? DIV_W'(1) : clock_divisor;
  assign cnt_next  = clkcnt_q + DIV_W'(1);
  // >= rather than == so a divisor lowered mid-count still fires on the next compare.
  assign tick_fire = (state_q == StRun) && (cnt_next >= div_eff);
  assign acc_sum   = acc_q + inc_q;
  assign step_hit  = tick_fire && !acc_sum[INC_W-1] && (acc_sum != '0);
  assign load_zero = (state_q == StLoad) && (head_dur == '0);
  assign run_done  = tick_fire && (tick_q == DUR_W'(1));
  assign retire    = !clear && (load_zero || run_done);

  // A retiring slot frees space in the same cycle, so a push is taken even when full.
  assign push_ready    = (count_q != CntW'(Depth)) || retire;
  assign push_fire     = push_valid && push_ready && !clear;
  assign others_stored = count_q > CntW'(1);

  assign step       = !clear && step_hit;
  assign move_done  = retire;
  assign dir        = dir_q;
  assign busy       = (state_q != StIdle);
  assign fill_level = count_q;
  assign underrun   = underrun_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_fire) begin
      wr_ptr_d = wr_ptr_q + BUFFER_BITS'(1);
    end
    if (retire) begin
      rd_ptr_d = rd_ptr_q + BUFFER_BITS'(1);
    end
    count_d = count_q + CntW'(push_fire) - CntW'(retire);
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    inc_d      = inc_q;
    incinc_d   = incinc_q;
    acc_d      = acc_q;
    clkcnt_d   = clkcnt_q;
    dir_d      = dir_q;
    underrun_d = underrun_q;
    unique case (state_q)
      StIdle: begin
        if ((count_q != '0) && enable) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        tick_d   = head_dur;
        inc_d    = head_inc;
        incinc_d = head_incinc;
        dir_d    = head_dir;
        clkcnt_d = '0;
        if (load_zero) begin
          state_d = StIdle;
          if (!others_stored && enable) begin
            underrun_d = 1'b1;
          end
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        clkcnt_d = cnt_next;
        if (tick_fire) begin
          clkcnt_d = '0;
          acc_d    = step_hit ? (acc_sum - StepSub) : acc_sum;
          inc_d    = inc_q + incinc_q;
          tick_d   = tick_q - DUR_W'(1);
          if (run_done) begin
            state_d = (others_stored && enable) ? StLoad : StIdle;
            if (!others_stored && enable) begin
              underrun_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push_fire) begin
      dir_mem[wr_ptr_q]    <= push_dir;
      dur_mem[wr_ptr_q]    <= push_duration;
      inc_mem[wr_ptr_q]    <= push_increment;
      incinc_mem[wr_ptr_q] <= push_incinc;
    end
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      tick_q     <= '0;
      inc_q      <= '0;
      incinc_q   <= '0;
      acc_q      <= '0;
      clkcnt_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      tick_q     <= tick_d;
      inc_q      <= inc_d;
      incinc_q   <= incinc_d;
      acc_q      <= acc_d;
      clkcnt_q   <= clkcnt_d;
      underrun_q <= underrun_d;
    end
  end

  // Direction survives abort; only reset clears it.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      dir_q <= 1'b0;
    end else if (!abort) begin
      dir_q <= dir_d;
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: step timing, FIFO fill/full behaviour, abort/reset
// flushing and zero-length segments, with events logged mid-cycle into queues.
module tb_move_scheduler;

  localparam logic [63:0] K = 64'h7fffffffffffff9c;

  logic        CLK = 1'b0;
  logic        resetn;
  logic        push_valid;
  logic        push_ready;
  logic        push_dir;
  logic [63:0] push_duration;
  logic [63:0] push_increment;
  logic [63:0] push_incinc;
  logic [23:0] clock_divisor;
  logic        enable;
  logic        abort;
  logic        step;
  logic        dir;
  logic        busy;
  logic        move_done;
  logic [2:0]  fill_level;
  logic        underrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int step_q[$];
  int done_q[$];
  int load_q[$];
  int fall_q[$];
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;

  always #5 CLK = ~CLK;

  move_scheduler #(
    .BUFFER_BITS(2),
    .DUR_W      (64),
    .INC_W      (64),
    .DIV_W      (24)
  ) dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .push_dir      (push_dir),
    .push_duration (push_duration),
    .push_increment(push_increment),
    .push_incinc   (push_incinc),
    .clock_divisor (clock_divisor),
    .enable        (enable),
    .abort         (abort),
    .step          (step),
    .dir           (dir),
    .busy          (busy),
    .move_done     (move_done),
    .fill_level    (fill_level),
    .underrun      (underrun)
  );

  always @(posedge CLK) cyc <= cyc + 1;

  // A LOAD cycle is the first busy cycle, or a busy cycle right after a retire.
  always @(negedge CLK) begin
    if (busy === 1'b1 && (!prev_busy || prev_done)) load_q.push_back(cyc);
    if (busy === 1'b0 && prev_busy) fall_q.push_back(cyc);
    if (step === 1'b1) step_q.push_back(cyc);
    if (move_done === 1'b1) done_q.push_back(cyc);
    prev_busy <= (busy === 1'b1);
    prev_done <= (move_done === 1'b1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clr_q();
    step_q.delete();
    done_q.delete();
    load_q.delete();
    fall_q.delete();
  endtask

  task automatic push(input logic d, input logic [63:0] dur, input logic [63:0] inc,
                      input logic [63:0] ii);
    push_valid     = 1'b1;
    push_dir       = d;
    push_duration  = dur;
    push_increment = inc;
    push_incinc    = ii;
    cycles(1);
    push_valid = 1'b0;
  endtask

  task automatic load3(input logic d, input logic [63:0] dur, input logic [63:0] inc);
    push_valid     = 1'b1;
    push_dir       = d;
    push_duration  = dur;
    push_increment = inc;
    push_incinc    = '0;
    cycles(3);
    push_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; abort = 1'b0; enable = 1'b0; push_valid = 1'b0; push_dir = 1'b0;
    push_duration = '0; push_increment = '0; push_incinc = '0; clock_divisor = 24'd4;
    cycles(2);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_step", 64'(step), 64'd0);
    chk("rst_done", 64'(move_done), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_ready", 64'(push_ready), 64'd1);
    chk("rst_dir", 64'(dir), 64'd0);
    resetn = 1'b1;

    // Zero increment: no steps, retire 10 cycles after LOAD at divisor 2.
    enable = 1'b1; clock_divisor = 24'd2; clr_q();
    push(1'b0, 64'd5, 64'd0, 64'd0);
    cycles(20);
    chk("t2_steps", 64'(step_q.size()), 64'd0);
    chk("t2_done_cnt", 64'(done_q.size()), 64'd1);
    chk("t2_done_lat", 64'(qget(done_q, 0) - qget(load_q, 0)), 64'd10);
    chk("t2_fill", 64'(fill_level), 64'd0);

    // Three steps, divisor 4.
    clr_q(); clock_divisor = 24'd4;
    push(1'b1, 64'd3, K, 64'd0);
    cycles(25);
    chk("t1_steps", 64'(step_q.size()), 64'd3);
    chk("t1_first", 64'(qget(step_q, 0) - qget(load_q, 0)), 64'd4);
    chk("t1_gap01", 64'(qget(step_q, 1) - qget(step_q, 0)), 64'd4);
    chk("t1_gap12", 64'(qget(step_q, 2) - qget(step_q, 1)), 64'd4);
    chk("t1_done_cnt", 64'(done_q.size()), 64'd1);
    chk("t1_done_last", 64'(qget(done_q, 0) - qget(step_q, 2)), 64'd0);
    chk("t1_busy_fall", 64'(qget(fall_q, 0) - qget(done_q, 0)), 64'd1);
    chk("t1_dir", 64'(dir), 64'd1);
    chk("t1_underrun", 64'(underrun), 64'd1);

    // Abort while idle clears underrun but keeps dir.
    abort = 1'b1; cycles(1); abort = 1'b0;
    chk("ab_dir", 64'(dir), 64'd1);
    chk("ab_underrun", 64'(underrun), 64'd0);

    // Fill to 4 with enable low, 5th push dropped, then push during a retire at full.
    enable = 1'b0; clock_divisor = 24'd1; clr_q();
    push_valid = 1'b1; push_dir = 1'b0; push_duration = 64'd2;
    push_increment = '0; push_incinc = '0;
    cycles(4);
    chk("t3_fill", 64'(fill_level), 64'd4);
    chk("t3_ready", 64'(push_ready), 64'd0);
    push_dir = 1'b1; push_duration = 64'd7;
    cycles(1);
    chk("t3_fill_drop", 64'(fill_level), 64'd4);
    push_duration = 64'd2; enable = 1'b1;
    cycles(3);
    chk("t4_retire", 64'(move_done), 64'd1);
    chk("t4_ready", 64'(push_ready), 64'd1);
    cycles(1);
    push_valid = 1'b0;
    chk("t4_fill", 64'(fill_level), 64'd4);
    chk("t4_underrun", 64'(underrun), 64'd0);
    cycles(20);
    chk("t3_done_cnt", 64'(done_q.size()), 64'd5);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_gap%0d", i), 64'(qget(done_q, i + 1) - qget(done_q, i)), 64'd3);
    end
    chk("t3_loads", 64'(load_q.size()), 64'd5);
    chk("t3_steps", 64'(step_q.size()), 64'd0);
    chk("t3_fill_end", 64'(fill_level), 64'd0);
    chk("t3_underrun", 64'(underrun), 64'd1);

    // Abort mid-RUN with 3 stored, after one step has left acc = 1.
    enable = 1'b0; clock_divisor = 24'd2;
    load3(1'b0, 64'd4, K);
    chk("t5_fill_pre", 64'(fill_level), 64'd3);
    enable = 1'b1;
    cycles(4);
    chk("t5_busy_pre", 64'(busy), 64'd1);
    abort = 1'b1; push_valid = 1'b1;
    #1;
    chk("t5_done_abort", 64'(move_done), 64'd0);
    cycles(1);
    abort = 1'b0; push_valid = 1'b0;
    chk("t5_fill", 64'(fill_level), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_step", 64'(step), 64'd0);
    chk("t5_done", 64'(move_done), 64'd0);
    clr_q();
    push(1'b0, 64'd1, 64'd0, 64'd0);
    cycles(8);
    chk("t5_acc_nostep", 64'(step_q.size()), 64'd0);
    chk("t5_acc_done", 64'(done_q.size()), 64'd1);

    // Reset mid-RUN with 3 stored; concurrent push dropped, dir cleared.
    enable = 1'b0;
    load3(1'b1, 64'd4, 64'd0);
    enable = 1'b1;
    cycles(4);
    chk("t5r_busy_pre", 64'(busy), 64'd1);
    chk("t5r_dir_pre", 64'(dir), 64'd1);
    resetn = 1'b0; push_valid = 1'b1;
    cycles(1);
    resetn = 1'b1; push_valid = 1'b0;
    chk("t5r_fill", 64'(fill_level), 64'd0);
    chk("t5r_busy", 64'(busy), 64'd0);
    chk("t5r_dir", 64'(dir), 64'd0);
    chk("t5r_underrun", 64'(underrun), 64'd0);

    // Zero-length segment then a one-tick stepping segment.
    enable = 1'b1; clock_divisor = 24'd1; clr_q();
    push(1'b0, 64'd0, 64'd0, 64'd0);
    push(1'b1, 64'd1, K, 64'd0);
    cycles(10);
    chk("t6_dones", 64'(done_q.size()), 64'd2);
    chk("t6_steps", 64'(step_q.size()), 64'd1);
    chk("t6_step_on_2nd", 64'(qget(step_q, 0) - qget(done_q, 1)), 64'd0);
    chk("t6_done_gap", 64'(qget(done_q, 1) - qget(done_q, 0)), 64'd3);
    chk("t6_underrun", 64'(underrun), 64'd1);
    chk("t6_fill", 64'(fill_level), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
